// File: rtl/midi_pkg.sv
// Shared MIDI constants, message-type encodings and byte-class record for the
// message parser and its byte classifier.
package midi_pkg;

  localparam logic [7:0] STATUS_MIN  = 8'h80;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [2:0] {
    MSG_NOTE_OFF = 3'd0,
    MSG_NOTE_ON  = 3'd1,
    MSG_POLY_AT  = 3'd2,
    MSG_CC       = 3'd3,
    MSG_PROG     = 3'd4,
    MSG_CHAN_AT  = 3'd5,
    MSG_BEND     = 3'd6
  } msg_type_e;

  typedef struct packed {
    logic       is_data;
    logic       is_chan_status;
    logic       is_rt;
    logic       is_sys_common;
    logic [1:0] data_len;
  } byte_class_t;

  // Number of data bytes that follow a status byte (0 for data/real-time bytes).
  function automatic logic [1:0] data_len(input logic [7:0] status);
    if (status < STATUS_MIN) return 2'd0;
    if (status < 8'hC0)      return 2'd2;
    if (status < 8'hE0)      return 2'd1;
    if (status < 8'hF0)      return 2'd2;
    case (status)
      8'hF1, 8'hF3: return 2'd1;
      8'hF2:        return 2'd2;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational decode of one received MIDI byte into its protocol class.
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0]  byte_in,
  output byte_class_t cls
);

  always_comb begin
    cls                = '0;
    cls.is_data        = ~byte_in[7];
    cls.is_chan_status = byte_in[7] && (byte_in < SYSEX_START);
    cls.is_rt          = (byte_in >= RT_MIN);
    cls.is_sys_common  = (byte_in >= SYSEX_START) && (byte_in < RT_MIN);
    cls.data_len       = data_len(byte_in);
  end

endmodule

// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: tracks (running) status, assembles channel voice
// messages, forwards real-time bytes and flags dropped bytes.
module midi_message_parser
  import midi_pkg::*;
#(
  parameter bit         CHAN_FILTER_EN      = 1'b0,
  parameter logic [3:0] CHAN_SEL            = 4'd0,
  parameter bit         NOTE_ON_ZERO_IS_OFF = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Byte_in,
  input  logic       Byte_valid,
  output logic       Msg_valid,
  output logic [2:0] Msg_type,
  output logic [3:0] Msg_channel,
  output logic [6:0] Msg_data1,
  output logic [6:0] Msg_data2,
  output logic       Rt_valid,
  output logic [7:0] Rt_byte,
  output logic       Err_pulse
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_D1 = 3'd1;
  localparam logic [2:0] ST_WAIT_D2 = 3'd2;
  localparam logic [2:0] ST_SKIP    = 3'd3;
  localparam logic [2:0] ST_SYSEX   = 3'd4;

  logic [2:0]  state;
  logic [7:0]  status_q;
  logic        rs_valid;
  logic [6:0]  d1_q;
  logic [1:0]  skip_cnt;
  byte_class_t cls;

  logic [1:0]  cur_len;
  logic        done, ch_ok;
  logic [2:0]  cmp_type;
  logic [6:0]  cmp_d1, cmp_d2;

  midi_byte_classify u_classify (.byte_in(Byte_in), .cls(cls));

  always_comb begin
    cur_len  = data_len(status_q);
    done     = Byte_valid && cls.is_data &&
               ((state == ST_WAIT_D2) ||
                (cur_len == 2'd1 && (state == ST_WAIT_D1 || (state == ST_IDLE && rs_valid))));
    cmp_d1   = (state == ST_WAIT_D2) ? d1_q : Byte_in[6:0];
    cmp_d2   = (cur_len == 2'd1) ? 7'd0 : Byte_in[6:0];
    cmp_type = status_q[6:4];
    // Velocity-0 Note On is reported as Note Off; running status is left as 9n.
    if (NOTE_ON_ZERO_IS_OFF && cmp_type == MSG_NOTE_ON && cmp_d2 == 7'd0)
      cmp_type = MSG_NOTE_OFF;
    ch_ok    = !CHAN_FILTER_EN || (status_q[3:0] == CHAN_SEL);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      status_q    <= '0;
      rs_valid    <= 1'b0;
      d1_q        <= '0;
      skip_cnt    <= '0;
      Msg_valid   <= 1'b0;
      Msg_type    <= '0;
      Msg_channel <= '0;
      Msg_data1   <= '0;
      Msg_data2   <= '0;
      Rt_valid    <= 1'b0;
      Rt_byte     <= '0;
      Err_pulse   <= 1'b0;
    end else begin
      Msg_valid <= 1'b0;
      Rt_valid  <= 1'b0;
      Err_pulse <= 1'b0;
      if (Byte_valid) begin
        if (cls.is_rt) begin
          Rt_valid <= 1'b1;
          Rt_byte  <= Byte_in;
        end else if (cls.is_chan_status) begin
          status_q  <= Byte_in;
          rs_valid  <= 1'b1;
          d1_q      <= '0;
          state     <= ST_WAIT_D1;
          Err_pulse <= (state == ST_WAIT_D2);
        end else if (cls.is_sys_common) begin
          case (Byte_in)
            SYSEX_START: begin
              rs_valid <= 1'b0;
              state    <= ST_SYSEX;
            end
            SYSEX_END: if (state == ST_SYSEX) state <= ST_IDLE;
            8'hF1, 8'hF2, 8'hF3: begin
              rs_valid <= 1'b0;
              skip_cnt <= cls.data_len;
              state    <= ST_SKIP;
            end
            default: begin
              rs_valid <= 1'b0;
              state    <= ST_IDLE;
            end
          endcase
        end else if (done) begin
          state <= ST_IDLE;
          if (ch_ok) begin
            Msg_valid   <= 1'b1;
            Msg_type    <= cmp_type;
            Msg_channel <= status_q[3:0];
            Msg_data1   <= cmp_d1;
            Msg_data2   <= cmp_d2;
          end
        end else begin
          case (state)
            ST_IDLE: begin
              if (!rs_valid) Err_pulse <= 1'b1;
              else begin
                d1_q  <= Byte_in[6:0];
                state <= ST_WAIT_D2;
              end
            end
            ST_WAIT_D1: begin
              d1_q  <= Byte_in[6:0];
              state <= ST_WAIT_D2;
            end
            ST_SKIP: begin
              skip_cnt <= skip_cnt - 2'd1;
              if (skip_cnt <= 2'd1) state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench: an unfiltered and a channel-2-filtered parser share one byte
// stream; expected messages and real-time bytes are queued and popped on output.
module tb_midi_message_parser;

  typedef struct {
    logic [2:0] t;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;

  logic       m0_valid, m1_valid, rt0_valid, rt1_valid, err0, err1;
  logic [2:0] m0_type, m1_type;
  logic [3:0] m0_ch, m1_ch;
  logic [6:0] m0_d1, m0_d2, m1_d1, m1_d2;
  logic [7:0] rt0_byte, rt1_byte;

  msg_t       q0[$], q1[$];
  logic [7:0] rtq0[$], rtq1[$];
  int n_cmp = 0, n_bad = 0;
  int err_exp = 0, err_seen0 = 0, err_seen1 = 0;

  always #5 clk = ~clk;

  midi_message_parser u_dut0 (
    .Clock(clk), .Reset(rst), .Byte_in(byte_in), .Byte_valid(byte_valid),
    .Msg_valid(m0_valid), .Msg_type(m0_type), .Msg_channel(m0_ch),
    .Msg_data1(m0_d1), .Msg_data2(m0_d2),
    .Rt_valid(rt0_valid), .Rt_byte(rt0_byte), .Err_pulse(err0)
  );

  midi_message_parser #(.CHAN_FILTER_EN(1'b1), .CHAN_SEL(4'd2)) u_dut1 (
    .Clock(clk), .Reset(rst), .Byte_in(byte_in), .Byte_valid(byte_valid),
    .Msg_valid(m1_valid), .Msg_type(m1_type), .Msg_channel(m1_ch),
    .Msg_data1(m1_d1), .Msg_data2(m1_d2),
    .Rt_valid(rt1_valid), .Rt_byte(rt1_byte), .Err_pulse(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_msg(input string tag, inout msg_t q[$],
                         input logic [2:0] t, input logic [3:0] ch,
                         input logic [6:0] d1, input logic [6:0] d2);
    msg_t e;
    chk({tag, "_expected"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_type"}, 32'(t),  32'(e.t));
      chk({tag, "_chan"}, 32'(ch), 32'(e.ch));
      chk({tag, "_d1"},   32'(d1), 32'(e.d1));
      chk({tag, "_d2"},   32'(d2), 32'(e.d2));
    end
  endtask

  task automatic pop_rt(input string tag, inout logic [7:0] q[$], input logic [7:0] b);
    chk({tag, "_expected"}, 32'(q.size() > 0), 32'd1);
    if (q.size() > 0) chk({tag, "_byte"}, 32'(b), 32'(q.pop_front()));
  endtask

  // Output monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (m0_valid)  pop_msg("msg0", q0, m0_type, m0_ch, m0_d1, m0_d2);
    if (m1_valid)  pop_msg("msg1", q1, m1_type, m1_ch, m1_d1, m1_d2);
    if (rt0_valid) pop_rt("rt0", rtq0, rt0_byte);
    if (rt1_valid) pop_rt("rt1", rtq1, rt1_byte);
    if (err0) err_seen0++;
    if (err1) err_seen1++;
  end

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Final byte of a message: queue the expectation, then check latency-1 pulse.
  task automatic send_msg(input logic [7:0] b, input logic [2:0] t, input logic [3:0] ch,
                          input logic [6:0] d1, input logic [6:0] d2);
    msg_t e;
    e.t = t; e.ch = ch; e.d1 = d1; e.d2 = d2;
    q0.push_back(e);
    if (ch == 4'd2) q1.push_back(e);
    send(b);
    chk("latency_msg0", 32'(m0_valid), 32'd1);
  endtask

  task automatic send_err(input logic [7:0] b);
    err_exp++;
    send(b);
    chk("latency_err0", 32'(err0), 32'd1);
  endtask

  task automatic send_rt(input logic [7:0] b);
    rtq0.push_back(b);
    rtq1.push_back(b);
    send(b);
  endtask

  task automatic checkpoint(input string tag);
    idle(2);
    chk({tag, "_q0_drained"},  32'(q0.size()),   32'd0);
    chk({tag, "_q1_drained"},  32'(q1.size()),   32'd0);
    chk({tag, "_rt_drained"},  32'(rtq0.size() + rtq1.size()), 32'd0);
    chk({tag, "_err_count0"},  32'(err_seen0),   32'(err_exp));
    chk({tag, "_err_count1"},  32'(err_seen1),   32'(err_exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_msg_valid", 32'(m0_valid),  32'd0);
    chk("rst_msg_type",  32'(m0_type),   32'd0);
    chk("rst_msg_chan",  32'(m0_ch),     32'd0);
    chk("rst_msg_d1",    32'(m0_d1),     32'd0);
    chk("rst_msg_d2",    32'(m0_d2),     32'd0);
    chk("rst_rt",        32'({rt0_valid, rt0_byte}), 32'd0);
    chk("rst_err",       32'(err0),      32'd0);

    // Data with no running status after reset is a protocol error.
    send_err(8'h45);
    checkpoint("cold_data");

    // Basic Note On, then outputs hold after the pulse.
    send(8'h90); send(8'h3C); send_msg(8'h64, 3'd1, 4'd0, 7'h3C, 7'h64);
    idle(3);
    chk("hold_valid", 32'(m0_valid), 32'd0);
    chk("hold_type",  32'(m0_type),  32'd1);
    chk("hold_d2",    32'(m0_d2),    32'h64);
    checkpoint("note_on");

    // Running status with velocity-0 Note On reported as Note Off.
    send(8'h93); send(8'h40); send_msg(8'h7F, 3'd1, 4'd3, 7'h40, 7'h7F);
    send(8'h40); send_msg(8'h00, 3'd0, 4'd3, 7'h40, 7'h00);
    checkpoint("running");

    // Real-time byte in the middle of a message.
    send(8'h90); send(8'h3C); send_rt(8'hF8);
    send_msg(8'h64, 3'd1, 4'd0, 7'h3C, 7'h64);
    checkpoint("rt_mid");

    // Program change, SysEx (with embedded RT), then data is an error.
    send(8'hC5); send_msg(8'h10, 3'd4, 4'd5, 7'h10, 7'h00);
    send(8'hF0); send(8'h01); send_rt(8'hFA); send(8'h02); send(8'hF7);
    send_err(8'h22);
    checkpoint("sysex");

    // Status in WAIT_D2 aborts the pending CC.
    send(8'hB0); send(8'h07); send_err(8'h90);
    send(8'h3C); send_msg(8'h40, 3'd1, 4'd0, 7'h3C, 7'h40);
    checkpoint("abort");

    // Reset mid-message discards partial data and running status.
    send(8'h90); send(8'h3C);
    do_reset();
    send_err(8'h40);
    checkpoint("reset_mid");

    // Channel filter: only ch2 reaches the filtered instance.
    send(8'h91); send(8'h3C); send_msg(8'h40, 3'd1, 4'd1, 7'h3C, 7'h40);
    send(8'h92); send(8'h3C); send_msg(8'h40, 3'd1, 4'd2, 7'h3C, 7'h40);
    checkpoint("filter");

    // Running status on a 1-data message, and pitch bend on ch2.
    send(8'hC3); send_msg(8'h05, 3'd4, 4'd3, 7'h05, 7'h00);
    send_msg(8'h06, 3'd4, 4'd3, 7'h06, 7'h00);
    send(8'hE2); send(8'h00); send_msg(8'h40, 3'd6, 4'd2, 7'h00, 7'h40);
    checkpoint("prog_bend");

    // System common skips; stray F7 is silent; F6 clears running status.
    send(8'hF2); send(8'h01); send(8'h02); send_err(8'h05);
    send(8'hF1); send(8'h01); send_err(8'h02);
    send(8'hF7);
    send(8'hA4); send(8'h10); send_msg(8'h20, 3'd2, 4'd4, 7'h10, 7'h20);
    send(8'hF6); send_err(8'h11);
    checkpoint("sys_common");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_message_parser.md
Name: midi_message_parser

Overview:
- Downstream stage of the MIDI serial receiver/decoder.
- Consumes the stream of received 8-bit MIDI bytes.
- Tracks status, including running status, and assembles complete channel voice messages.
- Emits one registered message per completed message, and forwards real-time bytes on a separate strobe; the LED/display and synth-control logic sit after it.

Parameters:
- CHAN_FILTER_EN, 0, 1 = only report channel messages whose channel equals CHAN_SEL.
- CHAN_SEL, 0, 4-bit channel number used when CHAN_FILTER_EN=1.
- NOTE_ON_ZERO_IS_OFF, 1, 1 = Note On (9n) with velocity 0 is reported as Note Off (8n).

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Byte_in  in  8  received MIDI byte; qualified by Byte_valid.
- Byte_valid  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- Msg_valid  out  1  one-cycle pulse when a channel message completes.
- Msg_type  out  3  status bits 6:4: 0=NoteOff 1=NoteOn 2=PolyAT 3=CC 4=Prog 5=ChanAT 6=Bend.
- Msg_channel  out  4  channel number, 0-15.
- Msg_data1  out  7  first data byte.
- Msg_data2  out  7  second data byte; 0 for 1-data messages.
- Rt_valid  out  1  one-cycle pulse for real-time bytes F8-FF.
- Rt_byte  out  8  the real-time byte.
- Err_pulse  out  1  one-cycle pulse when a byte is dropped as a protocol error.

Behaviour:
- Reset:
  - All outputs go to 0; state goes to IDLE; running status is cleared (rs_valid=0).
  - Reset mid-message discards all partial data.
- State machine states:
  - IDLE: waiting for a status byte, or for the first data byte under running status.
  - WAIT_D1: waiting for the first data byte.
  - WAIT_D2: waiting for the second data byte.
  - SKIP: a system common message is pending; its remaining data bytes are discarded.
  - SYSEX: inside a system exclusive message.
- Byte classes are decoded only on cycles with Byte_valid=1; all state is held otherwise.
- Real-time bytes (F8-FF):
  - Rt_valid=1 and Rt_byte=byte on the next cycle.
  - State, running status and partial data are untouched, in every state including SYSEX.
- Channel status bytes (80-EF):
  - Latch the status; set rs_valid=1; clear partial data; go to WAIT_D1. This applies from any state.
  - A status byte arriving in WAIT_D2 aborts the pending message, and Err_pulse=1.
- Data bytes (00-7F):
  - IDLE with rs_valid=1: the byte is the first data byte.
  - IDLE with rs_valid=0: the byte is dropped and Err_pulse=1.
  - WAIT_D1 with a Cn/Dn status: the message completes.
  - WAIT_D1 with any other status: store data1 and go to WAIT_D2.
  - WAIT_D2: the message completes.
  - On completion, return to IDLE with running status kept.
- F0: rs_valid=0; go to SYSEX. Data bytes are discarded; F7 or any non-real-time status exits SYSEX. A channel status byte is then processed as normal.
- F1 and F3: rs_valid=0; skip 1 data byte. F2: rs_valid=0; skip 2 data bytes. Both use the SKIP state with a 2-bit counter.
- F6, F4, F5: rs_valid=0; go to IDLE.
- F7 outside SYSEX: ignored; no error.
- Completion timing:
  - Msg_valid is asserted on the cycle after the final data byte's Byte_valid cycle (latency 1).
  - Msg_* outputs are registered, and hold their last value until the next completion.
- Channel filter:
  - With CHAN_FILTER_EN=1, a non-matching channel still runs the state machine and running status, but Msg_valid is suppressed.
- Note On with velocity 0:
  - With NOTE_ON_ZERO_IS_OFF=1, Msg_type=0 and Msg_data2=0.
  - Running status stays 9n.
- Err_pulse and Rt_valid may coincide with Msg_valid only if they are caused by different bytes. One byte per cycle means they are never simultaneous in practice.

Decomposition:
- Shared package midi_pkg holds:
  - Msg_type encodings.
  - Status-class constants: STATUS_MIN 8'h80, SYSEX_START 8'hF0, SYSEX_END 8'hF7, RT_MIN 8'hF8.
  - The data-length function: status -> 0/1/2.
- One sub-module, midi_byte_classify: combinational byte -> {is_data, is_chan_status, is_rt, is_sys_common, data_len}. The FSM stays in the parser.

Test Plan:
- Bytes 90 3C 64 -> one cycle after the 64: Msg_valid=1, type=1, ch=0, d1=3C, d2=64.
- Running status: 93 40 7F then 40 00 -> two messages: (type1 ch3 40 7F) then (type0 ch3 40 00) with NOTE_ON_ZERO_IS_OFF=1.
- Real time mid-message: 90 3C F8 64 -> Rt_valid with Rt_byte=F8 after the F8; then the Note On 3C 64 completes normally.
- SysEx: C5 10, F0 01 02 F7, then 22 -> first message Prog ch5 d1=10 d2=0; the 22 is dropped with Err_pulse=1 because SysEx cleared running status.
- Abort: B0 07 then 90 3C 40 -> Err_pulse after the 90; one message, NoteOn 3C 40; no CC emitted. Also: Reset asserted after 90 3C, then 40 -> Err_pulse, no Msg_valid.
- Filter: CHAN_FILTER_EN=1, CHAN_SEL=2; bytes 91 3C 40, 92 3C 40 -> exactly one Msg_valid, for ch2.
